// File: rtl/pcm_tx_pkg.sv
// Shared widths, FSM state encoding and frame formatting for the PCM SPI transmitter.
// Defining PCM_TX_PARITY_EN appends an even-parity bit after the sample LSB.
package pcm_tx_pkg;

    localparam int PCM_W = 24;

`ifdef PCM_TX_PARITY_EN
    localparam int FRAME_BITS = PCM_W + 1;
`else
    localparam int FRAME_BITS = PCM_W;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Parity bit makes the total number of ones in the frame even.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [PCM_W-1:0] sample);
`ifdef PCM_TX_PARITY_EN
        return {sample, ^sample};
`else
        return sample;
`endif
    endfunction

endpackage

// File: rtl/pcm_sync_fifo.sv
// Single-clock FIFO with registered level/full/empty and a combinational head read.
// Latency: a write is visible at rd_dat and in level one cycle later.
// Backpressure: writes while full are ignored unless a read happens in the same cycle.
module pcm_sync_fifo #(
    parameter  int WIDTH = 24,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;
    logic [LW-1:0]    level_nxt;

    assign rd_ok  = rd_vld && !empty;
    assign wr_ok  = wr_vld && (!full || rd_ok);
    assign rd_dat = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        case ({wr_ok, rd_ok})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    // Storage needs no reset: pointer reset alone empties the FIFO.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/pcm_spi_tx.sv
// PCM sample FIFO feeding a mode-0 SPI frame serializer, MSB first; PCM_TX_PARITY_EN adds even parity.
// Latency: a sample written on cycle t into an idle, empty transmitter drops spi_cs_n at the end of t+2.
// Backpressure: none upstream; samples arriving at a full FIFO are dropped and flagged on sticky ovf.
module pcm_spi_tx
    import pcm_tx_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PCM_W-1:0]       pcm_in,
    input  logic                   pcm_valid,
    input  logic                   tx_en,
    input  logic                   ovf_clr,
    output logic                   spi_sclk,
    output logic                   spi_cs_n,
    output logic                   spi_sdo,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   tx_busy,
    output logic                   ovf
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);

    state_t                state;
    logic [FRAME_BITS-1:0] shreg;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [PCM_W-1:0]      head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  drop;

    assign pop  = (state == LOAD);
    assign drop = pcm_valid && fifo_full && !pop;

    pcm_sync_fifo #(
        .WIDTH (PCM_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (pcm_valid),
        .wr_dat (pcm_in),
        .rd_vld (pop),
        .rd_dat (head),
        .level  (fifo_level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            spi_sclk <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_sdo  <= 1'b0;
            tx_busy  <= 1'b0;
            shreg    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_en && !fifo_empty) begin
                        state   <= LOAD;
                        tx_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    shreg    <= frame_word(head);
                    spi_sdo  <= head[PCM_W-1];
                    spi_cs_n <= 1'b0;
                    spi_sclk <= 1'b0;
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        div_cnt  <= '0;
                        spi_sclk <= !spi_sclk;
                        if (!spi_sclk) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            // Falling edge: next bit out; zeros shift in so sdo ends low.
                            shreg   <= shreg << 1;
                            spi_sdo <= shreg[FRAME_BITS-2];
                            if (bit_cnt == BIT_W'(FRAME_BITS)) state <= GAP;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    // First GAP cycle is the trailing chip-select hold; then CLK_DIV cycles deselected.
                    spi_cs_n <= 1'b1;
                    if (div_cnt == DIV_W'(CLK_DIV)) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_spi_tx.sv
// Randomized and directed stimulus for pcm_spi_tx, checked cycle by cycle against a frame-timeline model.
// The model tracks queued samples and the position inside the current frame, derived from frame timing rules.
module tb_pcm_spi_tx;
    localparam int DEPTH = 8;
    localparam int CD    = 4;
`ifdef PCM_TX_PARITY_EN
    localparam int FB = 25;
`else
    localparam int FB = 24;
`endif
    localparam int SHIFT_CYC = 2 * CD * FB;
    localparam int T         = 2 + SHIFT_CYC + CD;
    localparam int LOW       = 1 + SHIFT_CYC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] pcm_in = '0;
    logic        pcm_valid = 1'b0;
    logic        tx_en = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_sdo;
    logic [3:0]  fifo_level;
    logic        tx_busy;
    logic        ovf;

    int          n_vec = 0;
    int          n_err = 0;

    int          m_rem = 0;
    bit          m_ovf = 1'b0;
    logic [23:0] m_q[$];
    logic [FB-1:0] m_word = '0;
    logic [FB-1:0] sent_q[$];

    int          mon_low = 0;
    int          mon_n = 0;
    logic [FB-1:0] mon_bits = '0;
    logic        mon_cs = 1'b1;
    logic        mon_sclk = 1'b0;

    pcm_spi_tx #(.DEPTH(DEPTH), .CLK_DIV(CD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pcm_in     (pcm_in),
        .pcm_valid  (pcm_valid),
        .tx_en      (tx_en),
        .ovf_clr    (ovf_clr),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_sdo    (spi_sdo),
        .fifo_level (fifo_level),
        .tx_busy    (tx_busy),
        .ovf        (ovf)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FB-1:0] mk_word(input logic [23:0] s);
`ifdef PCM_TX_PARITY_EN
        return {s, ^s};
`else
        return s;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        sent_q.delete();
        m_rem    = 0;
        m_ovf    = 1'b0;
        mon_low  = 0;
        mon_n    = 0;
        mon_bits = '0;
        mon_cs   = 1'b1;
        mon_sclk = 1'b0;
    endtask

    // m_rem counts the busy cycles left in the current frame; T means the LOAD cycle.
    task automatic model_step();
        int lvl;
        bit pop, start, drop;
        if (!rst_n) begin
            model_reset();
            return;
        end
        lvl   = m_q.size();
        pop   = (m_rem == T);
        start = (m_rem == 0) && tx_en && (lvl > 0);
        drop  = pcm_valid && (lvl >= DEPTH) && !pop;
        if (pop) begin
            m_word = mk_word(m_q.pop_front());
            sent_q.push_back(m_word);
        end
        if (pcm_valid && !drop) m_q.push_back(pcm_in);
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        if (m_rem > 0) m_rem--;
        else if (start) m_rem = T;
    endtask

    task automatic check_cycle();
        int   k;
        bit   low, hi;
        logic exp_sdo;
        k       = T - 1 - m_rem;
        low     = (m_rem >= 1) && (m_rem <= T - 1) && (k <= SHIFT_CYC);
        hi      = low && (k < SHIFT_CYC) && (((k / CD) % 2) == 1);
        exp_sdo = (low && k < SHIFT_CYC) ? m_word[FB - 1 - k / (2 * CD)] : 1'b0;
        check("cs_n", 32'(spi_cs_n), 32'(!low));
        check("sclk", 32'(spi_sclk), 32'(hi));
        check("sdo", 32'(spi_sdo), 32'(exp_sdo));
        check("level", 32'(fifo_level), 32'(m_q.size()));
        check("busy", 32'(tx_busy), 32'(m_rem != 0));
        check("ovf", 32'(ovf), 32'(m_ovf));
        if (!spi_cs_n) begin
            mon_low++;
            if (spi_sclk && !mon_sclk) begin
                mon_bits = {mon_bits[FB-2:0], spi_sdo};
                mon_n++;
            end
        end else if (!mon_cs) begin
            check("frm_len", 32'(mon_low), 32'(LOW));
            check("frm_edges", 32'(mon_n), 32'(FB));
            check("frm_queued", 32'(sent_q.size() > 0), 32'd1);
            if (sent_q.size() > 0) check("frm_dat", 32'(mon_bits), 32'(sent_q.pop_front()));
            mon_low  = 0;
            mon_n    = 0;
            mon_bits = '0;
        end
        mon_cs   = spi_cs_n;
        mon_sclk = spi_sclk;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic push(input logic [23:0] s);
        pcm_in    = s;
        pcm_valid = 1'b1;
        tick();
        pcm_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max, input bit need_empty);
        int n = 0;
        while ((tx_busy || m_rem != 0 || (need_empty && fifo_level != 0)) && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(n < max), 32'd1);
    endtask

    task automatic wait_rise(input string tag, input int nth);
        int n = 0;
        while (!(m_rem >= 1 && m_rem <= T - 1 && (T - 1 - m_rem) == (2 * nth - 1) * CD) && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 3000), 32'd1);
    endtask

    initial begin
        logic [23:0] extra;

        // Reset state
        repeat (3) tick();
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        rst_n = 1'b1;
        tx_en = 1'b1;
        repeat (20) tick();
        check("no_frame_before_write", 32'(tx_busy), 32'd0);

        // Single frame, known pattern
        push(24'hA5C3F0);
        wait_idle("frame_a5c3f0_done", 3 * T, 1'b1);

        // Overflow with transmitter held off; 9th write coincides with ovf_clr
        tx_en = 1'b0;
        for (int i = 1; i <= 8; i++) push(24'(i));
        ovf_clr = 1'b1;
        push(24'd9);
        ovf_clr = 1'b0;
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_set", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);
        tx_en = 1'b1;
        wait_idle("drain_1_to_8", 10 * T, 1'b1);

        // Full FIFO with a write in the LOAD cycle
        tx_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(24'($urandom()));
        tx_en = 1'b1;
        begin
            int n = 0;
            while (!tx_busy && n < 10) begin
                tick();
                n++;
            end
            check("load_seen", 32'(tx_busy), 32'd1);
        end
        extra = 24'($urandom());
        push(extra);
        check("full_pop_level", 32'(fifo_level), 32'd8);
        check("full_pop_ovf", 32'(ovf), 32'd0);
        check("full_pop_tail", 32'(m_q[m_q.size() - 1]), 32'(extra));
        wait_idle("drain_full", 10 * T, 1'b1);

        // tx_en dropped mid-frame
        push(24'($urandom()));
        push(24'($urandom()));
        push(24'($urandom()));
        wait_rise("rise5_seen", 5);
        tx_en = 1'b0;
        wait_idle("halt_done", 2 * T, 1'b0);
        check("halt_level", 32'(fifo_level), 32'd2);
        repeat (30) tick();
        check("halt_stays_idle", 32'(tx_busy), 32'd0);
        tx_en = 1'b1;
        wait_idle("halt_drain", 4 * T, 1'b1);

        // Parity corner samples
        push(24'h000001);
        push(24'h000003);
        wait_idle("parity_drain", 4 * T, 1'b1);

        // Asynchronous reset mid-frame
        push(24'($urandom()));
        push(24'($urandom()));
        wait_rise("rise10_seen", 10);
        check("rise10_count", 32'(mon_n), 32'd10);
        rst_n = 1'b0;
        #1;
        check("arst_cs_n", 32'(spi_cs_n), 32'd1);
        check("arst_sclk", 32'(spi_sclk), 32'd0);
        check("arst_sdo", 32'(spi_sdo), 32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_busy", 32'(tx_busy), 32'd0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (300) tick();
        check("arst_no_frame", 32'(tx_busy), 32'd0);

        // Random traffic
        for (int i = 0; i < 5000; i++) begin
            pcm_valid = ($urandom_range(0, 49) == 0);
            pcm_in    = 24'($urandom());
            ovf_clr   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 299) == 0) tx_en = !tx_en;
            tick();
        end
        pcm_valid = 1'b0;
        ovf_clr   = 1'b0;
        tx_en     = 1'b1;
        wait_idle("random_drain", (DEPTH + 2) * T, 1'b1);
        check("frames_outstanding", 32'(sent_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
